dma_desc_splitter: RTL and testbench

//  Converts host-memory DMA commands (addr, len) into XDMA descriptor-bypass loads for one channel.

---
 rtl/dma_pkg.sv | 26 ++
 rtl/dma_desc_splitter.sv | 123 ++++++++++++
 tb/tb_dma_desc_splitter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared DMA types: command and descriptor records, splitter FSM states,
// and the XDMA descriptor-bypass control constant.
package dma_pkg;

    localparam int DMA_ADDR_W = 64;
    localparam int DMA_LEN_W  = 32;

    // Control word value used for XDMA descriptor-bypass loads
    localparam logic [15:0] XDMA_BYP_CTL = 16'h13;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] addr;
        logic [DMA_LEN_W-1:0]  len;
    } dma_cmd_t;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] addr;
        logic [DMA_LEN_W-1:0]  len;
    } dma_dsc_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } dsc_state_t;

endpackage

// File: rtl/dma_desc_splitter.sv
// dma_desc_splitter: turns (addr, len) host DMA commands into XDMA
// descriptor-bypass loads, splitting at BOUNDARY-aligned addresses and at
// MAX_DSC_LEN. Optional statistics counters are enabled by defining
// DMA_DESC_SPLITTER_STATS_EN (adds cmd_cnt / dsc_cnt outputs).
module dma_desc_splitter
    import dma_pkg::*;
#(
    parameter int ADDR_W      = DMA_ADDR_W,
    parameter int LEN_W       = DMA_LEN_W,
    parameter int MAX_DSC_LEN = 4096,
    parameter int BOUNDARY    = 4096
) (
    input  logic              pcie_clk,
    input  logic              pcie_rst,
    input  logic              s_cmd_valid,
    output logic              s_cmd_ready,
    input  logic [ADDR_W-1:0] s_cmd_addr,
    input  logic [LEN_W-1:0]  s_cmd_len,
    input  logic              dsc_byp_ready,
    output logic              dsc_byp_load,
    output logic [ADDR_W-1:0] dsc_byp_addr,
    output logic [LEN_W-1:0]  dsc_byp_len,
    output logic              busy,
    output logic              err_zero_len
`ifdef DMA_DESC_SPLITTER_STATS_EN
    ,
    output logic [31:0]       cmd_cnt,
    output logic [31:0]       dsc_cnt
`endif
);

    dsc_state_t        state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [LEN_W-1:0]  rem_len_q;
    logic              err_zero_len_q;

    // One extra bit so a full BOUNDARY-sized room is representable
    logic [LEN_W:0]    room;
    logic [LEN_W:0]    chunk;
    logic              cmd_accept;
    logic              last_dsc;

    assign s_cmd_ready  = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_ISSUE);
    assign cmd_accept   = s_cmd_valid && s_cmd_ready;
    assign dsc_byp_load = (state_q == ST_ISSUE) && dsc_byp_ready;
    assign dsc_byp_addr = cur_addr_q;
    assign dsc_byp_len  = chunk[LEN_W-1:0];
    assign err_zero_len = err_zero_len_q;
    assign last_dsc     = ({1'b0, rem_len_q} == chunk);

    // Descriptor size: smallest of remaining bytes, max descriptor size and
    // bytes left before the next BOUNDARY-aligned address
    always_comb begin
        room  = (LEN_W+1)'(BOUNDARY) - (LEN_W+1)'(cur_addr_q & ADDR_W'(BOUNDARY - 1));
        chunk = {1'b0, rem_len_q};
        if (chunk > (LEN_W+1)'(MAX_DSC_LEN)) begin
            chunk = (LEN_W+1)'(MAX_DSC_LEN);
        end
        if (chunk > room) begin
            chunk = room;
        end
    end

    // Command FSM: accept in IDLE, issue one descriptor per ready cycle in ISSUE
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state_q        <= ST_IDLE;
            cur_addr_q     <= '0;
            rem_len_q      <= '0;
            err_zero_len_q <= 1'b0;
        end else begin
            err_zero_len_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        if (s_cmd_len == '0) begin
                            err_zero_len_q <= 1'b1;
                        end else begin
                            cur_addr_q <= s_cmd_addr;
                            rem_len_q  <= s_cmd_len;
                            state_q    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (dsc_byp_load) begin
                        cur_addr_q <= cur_addr_q + ADDR_W'(chunk);
                        rem_len_q  <= rem_len_q - chunk[LEN_W-1:0];
                        if (last_dsc) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef DMA_DESC_SPLITTER_STATS_EN
    logic [31:0] cmd_cnt_q;
    logic [31:0] dsc_cnt_q;

    // Free-running statistics: accepted nonzero commands and issued descriptors
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            cmd_cnt_q <= '0;
            dsc_cnt_q <= '0;
        end else begin
            if (cmd_accept && (s_cmd_len != '0)) begin
                cmd_cnt_q <= cmd_cnt_q + 32'd1;
            end
            if (dsc_byp_load) begin
                dsc_cnt_q <= dsc_cnt_q + 32'd1;
            end
        end
    end

    assign cmd_cnt = cmd_cnt_q;
    assign dsc_cnt = dsc_cnt_q;
`endif

endmodule

// File: tb/tb_dma_desc_splitter.sv
// Self-checking bench for dma_desc_splitter: directed vector table,
// hand-written stall / zero-length / reset sequences, and randomized
// commands checked against a simple splitting model.
module tb_dma_desc_splitter;

    logic        pcie_clk;
    logic        pcie_rst;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [63:0] s_cmd_addr;
    logic [31:0] s_cmd_len;
    logic        dsc_byp_ready;
    logic        dsc_byp_load;
    logic [63:0] dsc_byp_addr;
    logic [31:0] dsc_byp_len;
    logic        busy;
    logic        err_zero_len;
`ifdef DMA_DESC_SPLITTER_STATS_EN
    logic [31:0] cmd_cnt;
    logic [31:0] dsc_cnt;
`endif

    dma_desc_splitter dut (
        .pcie_clk      (pcie_clk),
        .pcie_rst      (pcie_rst),
        .s_cmd_valid   (s_cmd_valid),
        .s_cmd_ready   (s_cmd_ready),
        .s_cmd_addr    (s_cmd_addr),
        .s_cmd_len     (s_cmd_len),
        .dsc_byp_ready (dsc_byp_ready),
        .dsc_byp_load  (dsc_byp_load),
        .dsc_byp_addr  (dsc_byp_addr),
        .dsc_byp_len   (dsc_byp_len),
        .busy          (busy),
        .err_zero_len  (err_zero_len)
`ifdef DMA_DESC_SPLITTER_STATS_EN
        ,
        .cmd_cnt       (cmd_cnt),
        .dsc_cnt       (dsc_cnt)
`endif
    );

    initial pcie_clk = 1'b0;
    always #5 pcie_clk = ~pcie_clk;

    typedef struct {
        logic [63:0] a;
        logic [31:0] l;
    } dsc_rec_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
        int          n;
        logic [63:0] da [4];
        logic [31:0] dl [4];
    } vec_t;

    dsc_rec_t exp_q[$];
    int       checks   = 0;
    int       failures = 0;
    int       exp_cmd  = 0;
    int       exp_dsc  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference splitting: walk the command, cutting at 4 KiB boundaries
    // and at the 4 KiB maximum descriptor size
    task automatic model_push(input logic [63:0] addr, input logic [31:0] len);
        logic [63:0]     a;
        longint unsigned rem;
        longint unsigned room;
        longint unsigned c;
        a   = addr;
        rem = len;
        while (rem != 0) begin
            room = 4096 - (a % 4096);
            c    = rem;
            if (c > 4096) c = 4096;
            if (c > room) c = room;
            exp_q.push_back('{a, 32'(c)});
            a   = a + c;
            rem = rem - c;
        end
    endtask

    // Descriptor monitor: every load must match the next expected descriptor
    always @(negedge pcie_clk) begin
        dsc_rec_t e;
        if (!pcie_rst) begin
            check("load_without_ready", 64'(dsc_byp_load & ~dsc_byp_ready), 64'd0);
            if (dsc_byp_load) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_load", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("dsc_addr", dsc_byp_addr, e.a);
                    check("dsc_len", 64'(dsc_byp_len), 64'(e.l));
                    $display("load addr=0x%0h len=0x%0h", dsc_byp_addr, dsc_byp_len);
                    exp_dsc++;
                end
            end
        end
    end

    // Present one command; returns at #1 after the accepting edge
    task automatic send_cmd(input logic [63:0] addr, input logic [31:0] len);
        int n = 0;
        while (!s_cmd_ready && n < 200) begin
            @(posedge pcie_clk); #1;
            n++;
        end
        if (!s_cmd_ready) check("cmd_ready_timeout", 64'd0, 64'd1);
        $display("cmd addr=0x%0h len=0x%0h", addr, len);
        s_cmd_valid = 1'b1;
        s_cmd_addr  = addr;
        s_cmd_len   = len;
        if (len != 0) exp_cmd++;
        @(posedge pcie_clk); #1;
        s_cmd_valid = 1'b0;
        s_cmd_addr  = {$urandom, $urandom};
        s_cmd_len   = $urandom;
    endtask

    // Run until all expected descriptors are out and the block is idle
    task automatic wait_idle(input int ready_pct, output int cycles);
        cycles = 0;
        while ((exp_q.size() != 0 || busy) && cycles < 300) begin
            @(posedge pcie_clk); #1;
            cycles++;
            dsc_byp_ready = ($urandom_range(0, 99) < ready_pct);
        end
        if (exp_q.size() != 0 || busy) begin
            check("idle_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    vec_t        vecs [5];
    int          cyc;
    logic [63:0] ra;
    logic [31:0] rl;

    initial begin
        pcie_rst      = 1'b1;
        s_cmd_valid   = 1'b0;
        s_cmd_addr    = 64'hDEAD_BEEF_0000_1234;
        s_cmd_len     = 32'h55;
        dsc_byp_ready = 1'b1;
        repeat (2) @(posedge pcie_clk);
        #1;
        check("rst_cmd_ready", 64'(s_cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_load", 64'(dsc_byp_load), 64'd0);
        check("rst_err", 64'(err_zero_len), 64'd0);
        check("rst_addr", dsc_byp_addr, 64'd0);
        check("rst_len", 64'(dsc_byp_len), 64'd0);
`ifdef DMA_DESC_SPLITTER_STATS_EN
        check("rst_cmd_cnt", 64'(cmd_cnt), 64'd0);
        check("rst_dsc_cnt", 64'(dsc_cnt), 64'd0);
`endif
        pcie_rst = 1'b0;
        @(posedge pcie_clk); #1;

        // Single descriptor, one-cycle latency, busy drops right after
        dsc_byp_ready = 1'b1;
        exp_q.push_back('{64'h1000, 32'h100});
        send_cmd(64'h1000, 32'h100);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_ready_low", 64'(s_cmd_ready), 64'd0);
        check("t1_load", 64'(dsc_byp_load), 64'd1);
        @(posedge pcie_clk); #1;
        check("t1_busy_drop", 64'(busy), 64'd0);
        check("t1_ready_back", 64'(s_cmd_ready), 64'd1);
        check("t1_pending", 64'(exp_q.size()), 64'd0);

        // Directed split vectors at full ready: one descriptor per cycle
        vecs[0] = '{64'h0FF0, 32'h40, 2,
                    '{64'h0FF0, 64'h1000, 64'h0, 64'h0}, '{32'h10, 32'h30, 32'h0, 32'h0}};
        vecs[1] = '{64'h0, 32'h3000, 3,
                    '{64'h0, 64'h1000, 64'h2000, 64'h0}, '{32'h1000, 32'h1000, 32'h1000, 32'h0}};
        vecs[2] = '{64'h1FFF, 32'h2, 2,
                    '{64'h1FFF, 64'h2000, 64'h0, 64'h0}, '{32'h1, 32'h1, 32'h0, 32'h0}};
        vecs[3] = '{64'h2800, 32'h1800, 2,
                    '{64'h2800, 64'h3000, 64'h0, 64'h0}, '{32'h800, 32'h1000, 32'h0, 32'h0}};
        vecs[4] = '{64'h10_0000_0F00, 32'h2101, 4,
                    '{64'h10_0000_0F00, 64'h10_0000_1000, 64'h10_0000_2000, 64'h10_0000_3000},
                    '{32'h100, 32'h1000, 32'h1000, 32'h1}};
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                exp_q.push_back('{vecs[i].da[k], vecs[i].dl[k]});
            end
            dsc_byp_ready = 1'b1;
            send_cmd(vecs[i].addr, vecs[i].len);
            wait_idle(100, cyc);
            check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].n));
        end

        // Stall: ready low for 10 cycles, outputs hold, inputs ignored
        dsc_byp_ready = 1'b0;
        exp_q.push_back('{64'h0FF0, 32'h10});
        exp_q.push_back('{64'h1000, 32'h30});
        send_cmd(64'h0FF0, 32'h40);
        s_cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_cmd_addr = {$urandom, $urandom};
            s_cmd_len  = $urandom;
            @(negedge pcie_clk);
            check("stall_load", 64'(dsc_byp_load), 64'd0);
            check("stall_addr", dsc_byp_addr, 64'h0FF0);
            check("stall_len", 64'(dsc_byp_len), 64'h10);
            @(posedge pcie_clk); #1;
        end
        s_cmd_valid   = 1'b0;
        dsc_byp_ready = 1'b1;
        wait_idle(100, cyc);
        check("stall_resume_cycles", 64'(cyc), 64'd2);

        // Zero-length command: single error pulse, no descriptor
        send_cmd(64'h1234, 32'h0);
        check("zl_err", 64'(err_zero_len), 64'd1);
        check("zl_ready", 64'(s_cmd_ready), 64'd1);
        check("zl_busy", 64'(busy), 64'd0);
        @(posedge pcie_clk); #1;
        check("zl_err_clear", 64'(err_zero_len), 64'd0);
        check("zl_no_load", 64'(exp_q.size()), 64'd0);

`ifdef DMA_DESC_SPLITTER_STATS_EN
        check("cmd_cnt_mid", 64'(cmd_cnt), 64'(exp_cmd));
        check("dsc_cnt_mid", 64'(dsc_cnt), 64'(exp_dsc));
`endif

        // Reset between the first and second descriptor of a 3-descriptor command
        dsc_byp_ready = 1'b0;
        exp_q.push_back('{64'h0, 32'h1000});
        send_cmd(64'h0, 32'h3000);
        dsc_byp_ready = 1'b1;
        @(posedge pcie_clk); #1;
        check("rst_mid_first_done", 64'(exp_q.size()), 64'd0);
        dsc_byp_ready = 1'b0;
        pcie_rst      = 1'b1;
        @(posedge pcie_clk); #1;
        exp_cmd = 0;
        exp_dsc = 0;
        check("rst_mid_idle", 64'(s_cmd_ready), 64'd1);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_addr", dsc_byp_addr, 64'd0);
        check("rst_mid_len", 64'(dsc_byp_len), 64'd0);
`ifdef DMA_DESC_SPLITTER_STATS_EN
        check("rst_mid_cmd_cnt", 64'(cmd_cnt), 64'd0);
        check("rst_mid_dsc_cnt", 64'(dsc_cnt), 64'd0);
`endif
        pcie_rst      = 1'b0;
        dsc_byp_ready = 1'b1;
        repeat (5) begin
            @(posedge pcie_clk); #1;
        end
        check("rst_mid_no_resume", 64'(busy), 64'd0);

        // Randomized commands with random ready against the model
        for (int i = 0; i < 40; i++) begin
            ra     = {$urandom, $urandom};
            ra[63] = 1'b0;
            if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFFF - 12'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0, 1:    rl = $urandom_range(1, 32);
                2, 3, 4: rl = $urandom_range(1, 32'h1000);
                7:       rl = 32'h0;
                default: rl = $urandom_range(1, 32'h3000);
            endcase
            model_push(ra, rl);
            dsc_byp_ready = ($urandom_range(0, 1) == 1);
            send_cmd(ra, rl);
            if (rl == 0) check("rand_zl_err", 64'(err_zero_len), 64'd1);
            wait_idle($urandom_range(30, 100), cyc);
        end

`ifdef DMA_DESC_SPLITTER_STATS_EN
        check("cmd_cnt_end", 64'(cmd_cnt), 64'(exp_cmd));
        check("dsc_cnt_end", 64'(dsc_cnt), 64'(exp_dsc));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
